// File: rtl/pdp8l_xbr_arbiter_if.sv
// Request/acknowledge ports for C/A/D plus the xbr block-RAM bus.
// slave: arbiter side; master: requesters and RAM side.
interface pdp8l_xbr_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          c_req,   a_req,   d_req;
  logic          c_write, a_write, d_write;
  logic [AW-1:0] c_addr,  a_addr,  d_addr;
  logic [DW-1:0] c_wdat,  a_wdat,  d_wdat;
  logic [DW-1:0] c_rdat,  a_rdat,  d_rdat;
  logic          c_ack,   a_ack,   d_ack;
  logic [AW-1:0] xbraddr;
  logic [DW-1:0] xbrwdat;
  logic [DW-1:0] xbrrdat;
  logic          xbrenab;
  logic          xbrwena;
  logic          busy;

  modport slave (
    input  c_req, a_req, d_req, c_write, a_write, d_write,
           c_addr, a_addr, d_addr, c_wdat, a_wdat, d_wdat, xbrrdat,
    output c_rdat, a_rdat, d_rdat, c_ack, a_ack, d_ack,
           xbraddr, xbrwdat, xbrenab, xbrwena, busy
  );

  modport master (
    output c_req, a_req, d_req, c_write, a_write, d_write,
           c_addr, a_addr, d_addr, c_wdat, a_wdat, d_wdat, xbrrdat,
    input  c_rdat, a_rdat, d_rdat, c_ack, a_ack, d_ack,
           xbraddr, xbrwdat, xbrenab, xbrwena, busy
  );
endinterface

// File: rtl/pdp8l_xbr_arbiter.sv
// Three-port block-RAM arbiter: C strict priority, A/D round-robin, 3-clock access.
// Optional grant/wait statistics enabled by defining XBR_STATS_EN.
module pdp8l_xbr_arbiter #(
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic CLOCK,
  input  logic RESET,
  pdp8l_xbr_arbiter_if.slave bus
`ifdef XBR_STATS_EN
  ,
  input  logic [1:0]  stat_sel,
  output logic [31:0] stat_data
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {PORT_C, PORT_A, PORT_D} port_t;
  typedef enum logic {RR_A, RR_D} rr_t;

  state_t state, state_n;
  port_t  owner, grant_port;
  rr_t    rr, rr_n;
  logic   grant;

  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdat;

  logic [AW-1:0] xbraddr_q;
  logic [DW-1:0] xbrwdat_q;
  logic          xbrenab_q, xbrwena_q;
  logic [DW-1:0] c_rdat_q, a_rdat_q, d_rdat_q;

  always_comb begin
    state_n    = state;
    rr_n       = rr;
    grant      = 1'b0;
    grant_port = PORT_C;
    case (state)
      ST_IDLE: begin
        if (bus.c_req) begin
          grant = 1'b1;  grant_port = PORT_C;
        end else if (rr == RR_A) begin
          if (bus.a_req)      begin grant = 1'b1; grant_port = PORT_A; end
          else if (bus.d_req) begin grant = 1'b1; grant_port = PORT_D; end
        end else begin
          if (bus.d_req)      begin grant = 1'b1; grant_port = PORT_D; end
          else if (bus.a_req) begin grant = 1'b1; grant_port = PORT_A; end
        end
        if (grant) begin
          state_n = ST_RUN;
          if (grant_port == PORT_A) rr_n = RR_D;
          if (grant_port == PORT_D) rr_n = RR_A;
        end
      end
      ST_RUN:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_write = bus.c_write;
    sel_addr  = bus.c_addr;
    sel_wdat  = bus.c_wdat;
    case (grant_port)
      PORT_A: begin
        sel_write = bus.a_write; sel_addr = bus.a_addr; sel_wdat = bus.a_wdat;
      end
      PORT_D: begin
        sel_write = bus.d_write; sel_addr = bus.d_addr; sel_wdat = bus.d_wdat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      rr        <= RR_A;
      owner     <= PORT_C;
      xbraddr_q <= '0;
      xbrwdat_q <= '0;
      xbrenab_q <= 1'b0;
      xbrwena_q <= 1'b0;
      c_rdat_q  <= '0;
      a_rdat_q  <= '0;
      d_rdat_q  <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      if (grant) begin
        owner     <= grant_port;
        xbraddr_q <= sel_addr;
        xbrwdat_q <= sel_wdat;
        xbrwena_q <= sel_write;
        xbrenab_q <= 1'b1;
      end
      if (state == ST_RUN) begin
        xbrenab_q <= 1'b0;
        xbrwena_q <= 1'b0;
        // Read data is captured only into the owning port's register.
        if (!xbrwena_q) begin
          case (owner)
            PORT_C:  c_rdat_q <= bus.xbrrdat;
            PORT_A:  a_rdat_q <= bus.xbrrdat;
            PORT_D:  d_rdat_q <= bus.xbrrdat;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.xbraddr = xbraddr_q;
  assign bus.xbrwdat = xbrwdat_q;
  assign bus.xbrenab = xbrenab_q;
  assign bus.xbrwena = xbrwena_q;
  assign bus.c_rdat  = c_rdat_q;
  assign bus.a_rdat  = a_rdat_q;
  assign bus.d_rdat  = d_rdat_q;
  assign bus.c_ack   = (state == ST_DONE) && (owner == PORT_C);
  assign bus.a_ack   = (state == ST_DONE) && (owner == PORT_A);
  assign bus.d_ack   = (state == ST_DONE) && (owner == PORT_D);
  assign bus.busy    = (state != ST_IDLE);

`ifdef XBR_STATS_EN
  logic [31:0] cnt_c, cnt_a, cnt_d, cur_wait, max_wait;
  logic        c_waiting;

  // C's own access in flight does not count as waiting.
  assign c_waiting = bus.c_req && !((state != ST_IDLE) && (owner == PORT_C));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt_c    <= '0;
      cnt_a    <= '0;
      cnt_d    <= '0;
      cur_wait <= '0;
      max_wait <= '0;
    end else begin
      if (grant) begin
        case (grant_port)
          PORT_C:  cnt_c <= cnt_c + 32'd1;
          PORT_A:  cnt_a <= cnt_a + 32'd1;
          PORT_D:  cnt_d <= cnt_d + 32'd1;
          default: ;
        endcase
      end
      if (grant && (grant_port == PORT_C)) begin
        if (cur_wait > max_wait) max_wait <= cur_wait;
        cur_wait <= '0;
      end else if (c_waiting && (cur_wait != '1)) begin
        cur_wait <= cur_wait + 32'd1;
      end
    end
  end

  always_comb begin
    case (stat_sel)
      2'd0:    stat_data = cnt_c;
      2'd1:    stat_data = cnt_a;
      2'd2:    stat_data = cnt_d;
      default: stat_data = max_wait;
    endcase
  end
`endif

endmodule

// File: tb/tb_pdp8l_xbr_arbiter.sv
// Directed bench for pdp8l_xbr_arbiter: vector table of single accesses plus
// multi-cycle sequences for round-robin, priority, non-preemption and reset abort.
module tb_pdp8l_xbr_arbiter;
  localparam int AW = 15;
  localparam int DW = 12;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  pdp8l_xbr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef XBR_STATS_EN
  logic [1:0]  stat_sel = 2'd0;
  logic [31:0] stat_data;
`endif

  pdp8l_xbr_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus)
`ifdef XBR_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_data(stat_data)
`endif
  );

  logic          req_v [3];
  logic          wr_v  [3];
  logic [AW-1:0] addr_v[3];
  logic [DW-1:0] wdat_v[3];

  assign bus.c_req = req_v[0];  assign bus.c_write = wr_v[0];
  assign bus.a_req = req_v[1];  assign bus.a_write = wr_v[1];
  assign bus.d_req = req_v[2];  assign bus.d_write = wr_v[2];
  assign bus.c_addr = addr_v[0]; assign bus.c_wdat = wdat_v[0];
  assign bus.a_addr = addr_v[1]; assign bus.a_wdat = wdat_v[1];
  assign bus.d_addr = addr_v[2]; assign bus.d_wdat = wdat_v[2];

  // Block RAM model: combinational read of the registered address, write on enable.
  logic [DW-1:0] mem [0:32767];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_dat = '0;
  assign bus.xbrrdat = mem[bus.xbraddr];
  always @(posedge CLOCK) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (bus.xbrenab && bus.xbrwena) mem[bus.xbraddr] <= bus.xbrwdat;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0:       return bus.c_ack;
      1:       return bus.a_ack;
      default: return bus.d_ack;
    endcase
  endfunction

  function automatic logic [DW-1:0] rdat_of(input int p);
    case (p)
      0:       return bus.c_rdat;
      1:       return bus.a_rdat;
      default: return bus.d_rdat;
    endcase
  endfunction

  int   cyc;
  logic acked_prev[3];
  int   order[$];
  int   ack_cyc[$];

  // One clock; requesters drop req on the edge where their ack was high.
  task automatic step(input bit keep);
    @(posedge CLOCK); #1;
    if (!keep)
      for (int p = 0; p < 3; p++) if (acked_prev[p]) req_v[p] = 1'b0;
    @(negedge CLOCK);
    cyc++;
    for (int p = 0; p < 3; p++) begin
      acked_prev[p] = ack_of(p);
      if (ack_of(p)) begin
        order.push_back(p);
        ack_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset(input bit check_state);
    RESET = 1'b1;
    for (int p = 0; p < 3; p++) begin
      req_v[p] = 1'b0; wr_v[p] = 1'b0; addr_v[p] = '0; wdat_v[p] = '0;
      acked_prev[p] = 1'b0;
    end
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    if (check_state) begin
      check("rst_c_ack", bus.c_ack, 0);
      check("rst_a_ack", bus.a_ack, 0);
      check("rst_d_ack", bus.d_ack, 0);
      check("rst_xbrenab", bus.xbrenab, 0);
      check("rst_xbrwena", bus.xbrwena, 0);
      check("rst_xbraddr", bus.xbraddr, 0);
      check("rst_xbrwdat", bus.xbrwdat, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_c_rdat", bus.c_rdat, 0);
      check("rst_a_rdat", bus.a_rdat, 0);
      check("rst_d_rdat", bus.d_rdat, 0);
    end
    RESET = 1'b0;
    cyc = 0;
    order.delete();
    ack_cyc.delete();
  endtask

  typedef struct {
    int            port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp_rdat;
  } vec_t;

  vec_t          vecs[8];
  logic [DW-1:0] shadow[3];

  task automatic run_vec(input int i);
    vec_t v;
    int   p, n;
    v = vecs[i];
    p = v.port;
    @(posedge CLOCK); #1;
    req_v[p] = 1'b1; wr_v[p] = v.wr; addr_v[p] = v.addr; wdat_v[p] = v.wdat;
    @(posedge CLOCK); @(negedge CLOCK);
    check($sformatf("v%0d_enab_run", i), bus.xbrenab, 1);
    check($sformatf("v%0d_addr", i), bus.xbraddr, v.addr);
    check($sformatf("v%0d_wena", i), bus.xbrwena, v.wr);
    check($sformatf("v%0d_busy_run", i), bus.busy, 1);
    if (v.wr) check($sformatf("v%0d_wdat", i), bus.xbrwdat, v.wdat);
    n = 0;
    do begin
      @(posedge CLOCK); @(negedge CLOCK);
      n++;
    end while (!ack_of(p) && n < 6);
    check($sformatf("v%0d_ack_delay", i), n, 1);
    check($sformatf("v%0d_enab_done", i), bus.xbrenab, 0);
    check($sformatf("v%0d_rdat", i), rdat_of(p), v.exp_rdat);
    for (int q = 0; q < 3; q++)
      if (q != p) check($sformatf("v%0d_rdat_other%0d", i, q), rdat_of(q), shadow[q]);
    @(posedge CLOCK); #1;
    req_v[p] = 1'b0;
    @(negedge CLOCK);
    check($sformatf("v%0d_ack_drop", i), ack_of(p), 0);
    check($sformatf("v%0d_busy_idle", i), bus.busy, 0);
    shadow[p] = v.exp_rdat;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int guard, c_start;

    vecs[0] = '{0, 1'b0, 15'h4123, 12'o0000, 12'o5252};
    vecs[1] = '{1, 1'b1, 15'h0007, 12'o1234, 12'o0000};
    vecs[2] = '{2, 1'b0, 15'h0007, 12'o0000, 12'o1234};
    vecs[3] = '{0, 1'b1, 15'h4123, 12'o7777, 12'o5252};
    vecs[4] = '{1, 1'b0, 15'h4123, 12'o0000, 12'o7777};
    vecs[5] = '{2, 1'b1, 15'h7fff, 12'o0001, 12'o1234};
    vecs[6] = '{0, 1'b0, 15'h7fff, 12'o0000, 12'o0001};
    vecs[7] = '{1, 1'b0, 15'h0000, 12'o0000, 12'o4444};
    for (int q = 0; q < 3; q++) shadow[q] = '0;

    // Preload RAM while held in reset.
    RESET = 1'b1;
    pre_we = 1'b1; pre_addr = 15'h4123; pre_dat = 12'o5252;
    @(posedge CLOCK); #1;
    pre_addr = 15'h0000; pre_dat = 12'o4444;
    @(posedge CLOCK); #1;
    pre_we = 1'b0;

    do_reset(1'b1);
`ifdef XBR_STATS_EN
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s); #1;
      check($sformatf("rst_stat%0d", s), stat_data, 0);
    end
`endif

    for (int i = 0; i < 8; i++) run_vec(i);
`ifdef XBR_STATS_EN
    stat_sel = 2'd0; #1; check("stat_grants_c", stat_data, 3);
    stat_sel = 2'd1; #1; check("stat_grants_a", stat_data, 3);
    stat_sel = 2'd2; #1; check("stat_grants_d", stat_data, 2);
    stat_sel = 2'd3; #1; check("stat_maxwait_idle", stat_data, 0);
`endif

    // A and D held high continuously: strict alternation starting with A.
    do_reset(1'b0);
    @(posedge CLOCK); #1;
    req_v[1] = 1'b1; addr_v[1] = 15'h0001;
    req_v[2] = 1'b1; addr_v[2] = 15'h0002;
    guard = 0;
    while (order.size() < 8 && guard < 60) begin step(1'b1); guard++; end
    check("rr_grant_count", order.size(), 8);
    for (int k = 0; k < order.size() && k < 8; k++)
      check($sformatf("rr_order%0d", k), order[k], (k % 2 == 0) ? 1 : 2);
    if (ack_cyc.size() >= 2) check("rr_ack_spacing", ack_cyc[1] - ack_cyc[0], 3);
    req_v[1] = 1'b0; req_v[2] = 1'b0;
    repeat (4) step(1'b1);

    // C arrives during D's RUN: D completes, then C.
    do_reset(1'b0);
    @(posedge CLOCK); #1;
    req_v[2] = 1'b1; wr_v[2] = 1'b0; addr_v[2] = 15'h0007;
    step(1'b0);
    check("pre_d_run_enab", bus.xbrenab, 1);
    check("pre_d_run_addr", bus.xbraddr, 15'h0007);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 15'h4123;
    c_start = cyc;
    guard = 0;
    while (order.size() < 2 && guard < 20) begin step(1'b0); guard++; end
    check("pre_ack_count", order.size(), 2);
    if (order.size() >= 2) begin
      check("pre_first_d", order[0], 2);
      check("pre_then_c", order[1], 0);
      check("pre_c_latency_le5", (ack_cyc[1] - c_start) <= 5, 1);
    end
    check("pre_d_rdat", bus.d_rdat, 12'o1234);
    check("pre_c_rdat", bus.c_rdat, 12'o7777);
`ifdef XBR_STATS_EN
    stat_sel = 2'd3; #1; check("stat_maxwait_pre", stat_data, 2);
`endif
    step(1'b0);

    // C, A, D together: C then A then D; pointer back at A afterwards.
    do_reset(1'b0);
    @(posedge CLOCK); #1;
    for (int p = 0; p < 3; p++) begin req_v[p] = 1'b1; wr_v[p] = 1'b0; end
    addr_v[0] = 15'h4123; addr_v[1] = 15'h0007; addr_v[2] = 15'h7fff;
    guard = 0;
    while (order.size() < 3 && guard < 30) begin step(1'b0); guard++; end
    check("all3_count", order.size(), 3);
    if (order.size() >= 3) begin
      check("all3_first_c", order[0], 0);
      check("all3_second_a", order[1], 1);
      check("all3_third_d", order[2], 2);
    end
    check("all3_c_rdat", bus.c_rdat, 12'o7777);
    check("all3_a_rdat", bus.a_rdat, 12'o1234);
    check("all3_d_rdat", bus.d_rdat, 12'o0001);
    step(1'b0);
    req_v[1] = 1'b1; req_v[2] = 1'b1;
    guard = 0;
    while (order.size() < 5 && guard < 30) begin step(1'b0); guard++; end
    check("ptr_count", order.size(), 5);
    if (order.size() >= 5) begin
      check("ptr_next_a", order[3], 1);
      check("ptr_then_d", order[4], 2);
    end
    step(1'b0);

    // RESET during RUN of a write aborts with no ack.
    do_reset(1'b0);
    @(posedge CLOCK); #1;
    req_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 15'h0100; wdat_v[1] = 12'o7070;
    step(1'b0);
    check("abort_run_enab", bus.xbrenab, 1);
    check("abort_run_wena", bus.xbrwena, 1);
    RESET = 1'b1;
    req_v[1] = 1'b0;
    @(posedge CLOCK); @(negedge CLOCK);
    check("abort_enab", bus.xbrenab, 0);
    check("abort_wena", bus.xbrwena, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_a_ack", bus.a_ack, 0);
    check("abort_xbraddr", bus.xbraddr, 0);
`ifdef XBR_STATS_EN
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s); #1;
      check($sformatf("abort_stat%0d", s), stat_data, 0);
    end
`endif
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    order.delete();
    for (int p = 0; p < 3; p++) acked_prev[p] = 1'b0;
    repeat (5) step(1'b0);
    check("abort_no_ack", order.size(), 0);
    check("abort_idle_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
